// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: FSM states, opcodes,
// ALU function codes and datapath select values.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, HALT, TRAP
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_MOV   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hC;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;

  localparam logic ADDR_PC   = 1'b0;
  localparam logic ADDR_OPND = 1'b1;
  localparam logic WSEL_ALU  = 1'b0;
  localparam logic WSEL_MEM  = 1'b1;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/control_sequencer_wait_timer.sv
// Memory wait timer: counts cycles spent waiting on mem_ack and flags the
// cycle in which one more unacknowledged cycle would hit MEM_TIMEOUT.
module wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) count <= '0;
    else if (enable)    count <= count + W'(1);
  end

  // The caller qualifies this with !mem_ack so an ack in this cycle still wins.
  assign expired = (count == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute controller for the 16-bit microcontroller core.
// One instruction in flight; outputs are decoded from state and inputs.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             zero_flag,
  input  logic             mem_ack,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic [2:0]       alu_op,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic             halted,
  output logic             trap,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  state_t state, next_state;
  logic   retire_now, bus_fault, expired, waiting;

  // Timer runs only while a bus request is outstanding and unacknowledged.
  assign waiting = (state == FETCH || state == MEM) && !mem_ack;

  wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!waiting),
    .enable  (waiting),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      retired <= '0;
      trap    <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= next_state;
      if (retire_now)          retired <= retired + CNT_W'(1);
      if (next_state == TRAP)  trap    <= 1'b1;
      if (bus_fault)           bus_err <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    retire_now = 1'b0;
    bus_fault  = 1'b0;
    case (state)
      IDLE:  if (start) next_state = FETCH;
      FETCH: begin
        if (mem_ack)      next_state = DECODE;
        else if (expired) begin next_state = TRAP; bus_fault = 1'b1; end
      end
      DECODE: begin
        if (is_alu_op(opcode)) next_state = EXEC;
        else case (opcode)
          OP_NOP, OP_JMP, OP_JZ: begin next_state = FETCH; retire_now = 1'b1; end
          OP_LOAD, OP_STORE:     next_state = MEM;
          OP_HALT:               begin next_state = HALT; retire_now = 1'b1; end
          default:               next_state = TRAP;
        endcase
      end
      EXEC: begin next_state = FETCH; retire_now = 1'b1; end
      MEM: begin
        if (mem_ack)      begin next_state = FETCH; retire_now = 1'b1; end
        else if (expired) begin next_state = TRAP; bus_fault = 1'b1; end
      end
      HALT:    if (start) next_state = FETCH;
      TRAP:    next_state = TRAP;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = ADDR_PC;
    alu_op   = ALU_ADD;
    rf_we    = 1'b0;
    rf_wsel  = WSEL_ALU;
    halted   = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
        pc_inc  = mem_ack;
      end
      DECODE: pc_load = (opcode == OP_JMP) || ((opcode == OP_JZ) && zero_flag);
      EXEC: begin
        alu_op = 3'(opcode - OP_ADD);
        rf_we  = 1'b1;
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_OPND;
        mem_we   = (opcode == OP_STORE);
        rf_we    = (opcode == OP_LOAD) && mem_ack;
        rf_wsel  = ((opcode == OP_LOAD) && mem_ack) ? WSEL_MEM : WSEL_ALU;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a directed vector table, then instruction-level
// sequences expanded into per-cycle expectations and compared cycle by cycle.
module tb_control_sequencer;

  localparam int TMO = 15;

  logic       clock, reset, start, zero_flag, mem_ack;
  logic [3:0] opcode;
  logic       ir_load, pc_inc, pc_load, mem_req, mem_we, addr_sel;
  logic [2:0] alu_op;
  logic       rf_we, rf_wsel, halted, trap, bus_err;
  logic [3:0] retired;

  control_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode),
    .zero_flag(zero_flag), .mem_ack(mem_ack), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .alu_op(alu_op), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .halted(halted), .trap(trap), .bus_err(bus_err), .retired(retired)
  );

  typedef struct packed {
    logic       ir_load, pc_inc, pc_load, mem_req, mem_we, addr_sel;
    logic [2:0] alu_op;
    logic       rf_we, rf_wsel, halted, trap, bus_err;
    logic [3:0] retired;
  } out_t;

  typedef struct packed {
    logic       rst, start;
    logic [3:0] op;
    logic       zf, ack;
    out_t       exp;
  } vec_t;

  int         total = 0, bad = 0;
  vec_t       q[$];
  logic [3:0] ret;    // instructions retired so far, modulo 16

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic out_t mk(bit ir, bit pi, bit pl, bit mr, bit mw, bit as,
                              logic [2:0] alu, bit rw, bit ws, bit h, bit t,
                              bit be, logic [3:0] r);
    out_t o;
    o = '{ir, pi, pl, mr, mw, as, alu, rw, ws, h, t, be, r};
    return o;
  endfunction

  task automatic apply(input vec_t v, input string nm, input int idx);
    out_t act;
    reset = v.rst; start = v.start; opcode = v.op; zero_flag = v.zf; mem_ack = v.ack;
    @(negedge clock);
    act = '{ir_load, pc_inc, pc_load, mem_req, mem_we, addr_sel, alu_op,
            rf_we, rf_wsel, halted, trap, bus_err, retired};
    total++;
    if (act !== v.exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, v.exp);
    end
    @(posedge clock); #1;
  endtask

  task automatic run_q(input string nm);
    foreach (q[i]) apply(q[i], nm, i);
    q.delete();
  endtask

  task automatic push(input logic rst, input logic st, input logic [3:0] op,
                      input logic zf, input logic ack, input out_t e);
    vec_t v;
    v = '{rst, st, op, zf, ack, e};
    q.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    ret = '0;
  endtask

  // Reset-state check followed by the start pulse that leaves IDLE.
  task automatic add_start();
    push(0, 0, 4'($urandom), 1'($urandom), 1'($urandom), '0);
    push(0, 1, 4'($urandom), 1'($urandom), 1'($urandom), '0);
  endtask

  // One instruction: fetch with fw wait cycles, decode, then its own phase.
  task automatic add_instr(input logic [3:0] op, input int fw, input int mw,
                           input logic zf, input int hw);
    out_t e;
    bit   alu  = (op >= 4'h3 && op <= 4'h8);
    bit   memo = (op == 4'h1 || op == 4'h2);
    bit   ill  = (op == 4'hB || op >= 4'hD);
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.mem_req = 1; e.ir_load = (i == fw); e.pc_inc = (i == fw); e.retired = ret;
      push(0, 1'($urandom), 4'($urandom), 1'($urandom), (i == fw), e);
    end
    e = '0; e.retired = ret;
    e.pc_load = (op == 4'h9) || (op == 4'hA && zf);
    push(0, 1'($urandom), op, zf, 1'($urandom), e);
    if (!alu && !memo && !ill) ret++;
    if (alu) begin
      e = '0; e.alu_op = 3'(op - 4'h3); e.rf_we = 1; e.retired = ret;
      push(0, 1'($urandom), op, 1'($urandom), 1'($urandom), e);
      ret++;
    end
    if (memo) begin
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.mem_req = 1; e.addr_sel = 1; e.mem_we = (op == 4'h2);
        e.rf_we = (op == 4'h1) && (i == mw); e.rf_wsel = e.rf_we; e.retired = ret;
        push(0, 1'($urandom), op, 1'($urandom), (i == mw), e);
      end
      ret++;
    end
    if (op == 4'hC) begin
      for (int k = 0; k <= hw; k++) begin
        e = '0; e.halted = 1; e.retired = ret;
        push(0, (k == hw), 4'($urandom), 1'($urandom), 1'($urandom), e);
      end
    end
    if (ill) begin
      for (int k = 0; k < 3; k++) begin
        e = '0; e.trap = 1; e.retired = ret;
        push(0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), e);
      end
    end
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
  endfunction

  vec_t tbl[8];
  logic [3:0] legal[12];

  initial begin
    // ADD: reset, start, two fetch wait cycles, decode, one execute cycle.
    tbl[0] = '{0, 0, 4'h0, 0, 0, mk(0,0,0,0,0,0,3'd0,0,0,0,0,0,4'd0)};
    tbl[1] = '{0, 1, 4'h0, 0, 0, mk(0,0,0,0,0,0,3'd0,0,0,0,0,0,4'd0)};
    tbl[2] = '{0, 0, 4'h0, 0, 0, mk(0,0,0,1,0,0,3'd0,0,0,0,0,0,4'd0)};
    tbl[3] = '{0, 0, 4'h0, 0, 0, mk(0,0,0,1,0,0,3'd0,0,0,0,0,0,4'd0)};
    tbl[4] = '{0, 0, 4'h0, 0, 1, mk(1,1,0,1,0,0,3'd0,0,0,0,0,0,4'd0)};
    tbl[5] = '{0, 0, 4'h3, 0, 0, mk(0,0,0,0,0,0,3'd0,0,0,0,0,0,4'd0)};
    tbl[6] = '{0, 0, 4'h3, 0, 0, mk(0,0,0,0,0,0,3'd0,1,0,0,0,0,4'd0)};
    tbl[7] = '{0, 0, 4'h0, 0, 0, mk(0,0,0,1,0,0,3'd0,0,0,0,0,0,4'd1)};
    legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hC};

    reset = 1'b1; start = 0; opcode = 0; zero_flag = 0; mem_ack = 0;
    @(posedge clock); #1;
    do_reset();
    for (int i = 0; i < 8; i++) apply(tbl[i], "add_tbl", i);

    // LOAD / STORE with 3 memory wait cycles, then JZ taken and not taken.
    do_reset(); add_start();
    add_instr(4'h1, 0, 3, 0, 0);
    add_instr(4'h2, 1, 3, 0, 0);
    add_instr(4'hA, 0, 0, 1, 0);
    add_instr(4'hA, 0, 0, 0, 0);
    add_instr(4'h9, 0, 0, 0, 0);
    run_q("ldst_jz");

    // Fetch never acknowledged: trap after exactly TMO wait cycles.
    do_reset(); add_start();
    add_instr(4'h0, 0, 0, 0, 0);
    for (int i = 0; i < TMO; i++) push(0, 0, 4'h0, 0, 0, mk(0,0,0,1,0,0,3'd0,0,0,0,0,0,ret));
    for (int i = 0; i < 3; i++) push(0, 1, 4'h0, 0, 1, mk(0,0,0,0,0,0,3'd0,0,0,0,1,1,ret));
    run_q("fetch_tmo");

    // Ack on the last allowed cycle wins, in both FETCH and MEM.
    do_reset(); add_start();
    add_instr(4'h1, TMO - 1, TMO - 1, 0, 0);
    add_instr(4'h0, 0, 0, 0, 0);
    run_q("ack_wins");

    // Memory phase never acknowledged.
    do_reset(); add_start();
    add_instr(4'h3, 0, 0, 0, 0);
    add_instr(4'h0, 0, 0, 0, 0);
    for (int i = 0; i <= 0; i++) push(0, 0, 4'h0, 0, 1, mk(1,1,0,1,0,0,3'd0,0,0,0,0,0,ret));
    push(0, 0, 4'h2, 0, 0, mk(0,0,0,0,0,0,3'd0,0,0,0,0,0,ret));
    for (int i = 0; i < TMO; i++) push(0, 0, 4'h2, 0, 0, mk(0,0,0,1,1,1,3'd0,0,0,0,0,0,ret));
    push(0, 0, 4'h2, 0, 0, mk(0,0,0,0,0,0,3'd0,0,0,0,1,1,ret));
    run_q("mem_tmo");

    // Illegal opcode traps without bus error and is not retired.
    do_reset(); add_start();
    add_instr(4'h4, 0, 0, 0, 0);
    add_instr(4'hE, 1, 0, 0, 0);
    run_q("illegal");

    // HALT then resume; reset mid memory wait returns to IDLE.
    do_reset(); add_start();
    add_instr(4'hC, 0, 0, 0, 2);
    add_instr(4'h8, 0, 0, 0, 0);
    for (int i = 0; i < 1; i++) push(0, 0, 4'h0, 0, 1, mk(1,1,0,1,0,0,3'd0,0,0,0,0,0,ret));
    push(0, 0, 4'h1, 0, 0, mk(0,0,0,0,0,0,3'd0,0,0,0,0,0,ret));
    push(0, 0, 4'h1, 0, 0, mk(0,0,0,1,0,1,3'd0,0,0,0,0,0,ret));
    push(1, 0, 4'h1, 0, 0, mk(0,0,0,1,0,1,3'd0,0,0,0,0,0,ret));
    push(0, 0, 4'h1, 0, 1, '0);
    push(0, 0, 4'h1, 0, 1, '0);
    run_q("halt_rst");

    // Seventeen NOPs wrap the 4-bit counter to 1.
    do_reset(); add_start();
    for (int i = 0; i < 17; i++) add_instr(4'h0, 0, 0, 0, 0);
    push(0, 0, 4'h0, 0, 0, mk(0,0,0,1,0,0,3'd0,0,0,0,0,0,4'd1));
    run_q("wrap");

    // Random legal programs.
    for (int r = 0; r < 4; r++) begin
      do_reset(); add_start();
      for (int n = 0; n < 40; n++) begin
        add_instr(legal[$urandom_range(0, 11)], rand_wait(), rand_wait(),
                  1'($urandom), int'($urandom_range(0, 3)));
        run_q("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
